// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and constants for the multicycle sequencing controller
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU_R   = 3'd0,
        OP_ALU_I   = 3'd1,
        OP_LOAD    = 3'd2,
        OP_STORE   = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_JUMP    = 3'd5,
        OP_HALT    = 3'd6,
        OP_ILLEGAL = 3'd7
    } opclass_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] FAULT_NONE          = 2'd0;
    localparam logic [1:0] FAULT_FETCH_TIMEOUT = 2'd1;
    localparam logic [1:0] FAULT_DATA_TIMEOUT  = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL_OP    = 2'd3;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory request cycles and flags a timeout
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);
    localparam bit            ENABLED = (TIMEOUT > 0);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear || ready) begin
            wait_cnt_d = '0;
        end else if (req) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    // A ready arriving on the limit cycle still completes the request.
    assign expired = ENABLED && req && !ready && (wait_cnt_q == LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with timeout, halt and retire counters
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       opclass,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             mem2reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    opclass_e         op_q, op_d;
    logic [1:0]       fcode_q, fcode_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             issued_q, issued_d;

    logic             stalled;
    logic             retire;
    logic             expired;
    logic             req_c, we_c, irw_c, pcw_c, rw_c;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .req     (req_c),
        .ready   (mem_ready),
        .clear   (state_d != state_q),
        .expired (expired)
    );

    // Stall only freezes a memory phase before its request goes out.
    assign stalled = stall && !issued_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fcode_d = fcode_q;
        retire  = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        rw_c    = 1'b0;
        iord    = 1'b0;
        pc_src  = PC_SRC_SEQ;
        mem2reg = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (!stalled) begin
                    req_c = 1'b1;
                    if (mem_ready) begin
                        irw_c   = 1'b1;
                        pcw_c   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (expired) begin
                        fcode_d = FAULT_FETCH_TIMEOUT;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DECODE: begin
                if (!stalled) begin
                    op_d = opclass_e'(opclass);
                    case (opclass_e'(opclass))
                        OP_JUMP: begin
                            pcw_c   = 1'b1;
                            pc_src  = PC_SRC_JUMP;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        OP_HALT: begin
                            retire  = 1'b1;
                            state_d = ST_HALT;
                        end
                        OP_ILLEGAL: begin
                            fcode_d = FAULT_ILLEGAL_OP;
                            state_d = ST_FAULT;
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                if (!stalled) begin
                    case (op_q)
                        OP_LOAD, OP_STORE: state_d = ST_MEM;
                        OP_BRANCH: begin
                            pcw_c   = zero;
                            pc_src  = PC_SRC_BRANCH;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_WB;
                    endcase
                end
            end
            ST_MEM: begin
                iord = 1'b1;
                if (!stalled) begin
                    req_c = 1'b1;
                    we_c  = (op_q == OP_STORE);
                    if (mem_ready) begin
                        if (op_q == OP_STORE) begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (expired) begin
                        fcode_d = FAULT_DATA_TIMEOUT;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_WB: begin
                if (!stalled) begin
                    rw_c    = 1'b1;
                    mem2reg = (op_q == OP_LOAD);
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT, ST_FAULT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    assign issued_d  = req_c && !mem_ready && !expired;
    assign cycles_d  = (state_q == ST_HALT || state_q == ST_FAULT) ? cycles_q : cycles_q + CNT_W'(1);
    assign instret_d = instret_q + CNT_W'(retire);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            op_q      <= OP_ALU_R;
            fcode_q   <= FAULT_NONE;
            cycles_q  <= '0;
            instret_q <= '0;
            issued_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fcode_q   <= fcode_d;
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
            issued_q  <= issued_d;
        end
    end

    // Reset holds FETCH, so strobes are gated to stay quiet while reset is low.
    assign mem_req    = req_c & reset;
    assign mem_we     = we_c & reset;
    assign ir_write   = irw_c & reset;
    assign pc_write   = pcw_c & reset;
    assign reg_write  = rw_c & reset;
    assign state      = state_q;
    assign halted     = (state_q == ST_HALT);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fcode_q;
    assign cycles     = cycles_q;
    assign instret    = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for the next-generation multicycle datapath; replaces the single-cycle control path.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared instruction/data memory with a ready handshake.
- Drives datapath strobes, detects memory timeouts and illegal opcodes, and keeps cycle and retired-instruction counters.

Parameters:
- CNT_W, 32: width of the cycle and instret counters.
- TIMEOUT, 15: maximum memory wait cycles before a fault. 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low; asserted at 0.
- stall  in  1  external freeze request.
- opclass  in  3  decoded class: 0 ALU-R, 1 ALU-I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 HALT, 7 ILLEGAL.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write request; only valid with mem_req.
- iord  out  1  address select: 0 PC, 1 ALU result.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  2  PC source: 0 PC+4, 1 branch target, 2 jump target.
- reg_write  out  1  register file write.
- mem2reg  out  1  writeback data select: 1 memory, 0 ALU.
- state  out  3  current state.
- halted  out  1  sticky halt indication.
- fault  out  1  sticky fault indication.
- fault_code  out  2  1 fetch timeout, 2 data timeout, 3 illegal opcode.
- cycles  out  CNT_W  cycle count.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5, FAULT 6.
- Reset low (asynchronous):
  - state=FETCH; cycles, instret, wait_cnt, fault_code and the latched opclass all 0.
  - halted=0, fault=0.
  - All strobes (mem_req, ir_write, pc_write, reg_write, mem_we) forced 0 while reset is low.
- FETCH:
  - mem_req=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. These strobes are Mealy on mem_ready, same cycle.
- DECODE: latch opclass and dispatch.
  - ALU-R/ALU-I/LOAD/STORE/BRANCH: go to EXEC.
  - JUMP: pc_write=1, pc_src=2, instret+1, go to FETCH.
  - HALT: instret+1, go to HALT.
  - ILLEGAL: fault_code=3, go to FAULT.
- EXEC:
  - ALU classes: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_write=zero, pc_src=1, instret+1, go to FETCH. Instret increments whether or not the branch is taken.
- MEM:
  - mem_req=1, iord=1, mem_we=(latched class==STORE).
  - On mem_ready: STORE retires (instret+1) and goes to FETCH; LOAD goes to WB.
- WB: reg_write=1, mem2reg=(latched class==LOAD), instret+1, go to FETCH.
- Latency with zero-wait memory:
  - ALU: 4 cycles. LOAD: 5. STORE: 4. BRANCH: 3. JUMP: 2.
  - Each memory wait cycle adds 1.
- Timeout:
  - wait_cnt increments each cycle mem_req=1 and mem_ready=0; it clears on mem_ready or on leaving the state.
  - If mem_ready=0 while wait_cnt==TIMEOUT (TIMEOUT>0), go to FAULT with code 1 (from FETCH) or 2 (from MEM).
  - mem_ready on that same cycle wins; no fault.
- Stall:
  - Honoured in DECODE, EXEC and WB, and in FETCH/MEM only while wait_cnt==0 and the request has not yet been issued.
  - While honoured: state held, all strobes 0, counters other than cycles frozen.
  - Once mem_req is issued it is held until mem_ready or timeout; stall is ignored until then.
- HALT/FAULT:
  - Sticky until reset; all strobes 0.
  - halted=1 in HALT; fault=1 in FAULT with fault_code holding its value.
  - cycles frozen in both.
- Counters:
  - cycles increments every clock outside reset, HALT and FAULT.
  - Both counters wrap modulo 2^CNT_W with no saturation.
  - Simultaneous retire and wrap is legal.
- Strobe outputs are combinational from state, the latched opclass, zero and mem_ready. All state and counters are registered.

Decomposition:
- Package multicycle_pkg holds:
  - state enum;
  - opclass enum;
  - pc_src constants;
  - fault_code constants.
- One sub-module, mem_wait_timer:
  - parameterised by TIMEOUT;
  - inputs: req, ready, clear;
  - output: expired;
  - counter width $clog2(TIMEOUT+1), minimum 1.

Test Plan:
- ALU-R, mem_ready tied 1 -> states 0,1,2,4,0; reg_write high exactly 1 cycle in WB; instret=1 and cycles=4 after the first instruction.
- LOAD, MEM-phase mem_ready delayed 3 cycles -> mem_req=1, iord=1, mem_we=0 for 4 cycles; WB has mem2reg=1; instruction takes 8 cycles; instret=1.
- BRANCH with zero=1 then zero=0 -> EXEC shows pc_write=1/pc_src=1 then pc_write=0; instret increments by 2 in total.
- TIMEOUT=4, FETCH mem_ready held 0 -> mem_req high for 5 cycles, then state=6, fault=1, fault_code=1; strobes 0 and cycles frozen until reset.
- stall high 3 cycles in DECODE, then opclass=ILLEGAL -> state held at 1 with cycles +3 and no strobes; then FAULT with fault_code=3.
- opclass=HALT -> state=5, halted=1, instret+1, cycles frozen; then reset pulsed low mid-MEM of a later run -> state=0 and counters 0 immediately, before the next clock edge.
